// File: rtl/fp32_pkg.sv
// Shared fp32 definitions: FSM state encoding, format constants and small
// result-building helpers used by the fp32 arithmetic blocks.
package fp32_pkg;

   typedef enum logic [3:0] {
      GET_A         = 4'd0,
      GET_B         = 4'd1,
      UNPACK        = 4'd2,
      SPECIAL_CASES = 4'd3,
      NORMALISE_A   = 4'd4,
      NORMALISE_B   = 4'd5,
      MULTIPLY_0    = 4'd6,
      MULTIPLY_1    = 4'd7,
      NORMALISE_1   = 4'd8,
      NORMALISE_2   = 4'd9,
      ROUND         = 4'd10,
      PACK          = 4'd11,
      PUT_Z         = 4'd12
   } fp32_state_t;

   localparam logic [31:0]        QNAN        = 32'hFFC00000;
   localparam logic signed [9:0]  EXP_BIAS    = 10'sd127;
   localparam logic signed [9:0]  EXP_MIN     = -10'sd126;
   localparam logic signed [9:0]  EXP_MAX     = 10'sd127;
   localparam logic signed [9:0]  EXP_SPECIAL = 10'sd128;
   // Unbiased exponent of an all-zero exponent field (zero or denormal).
   localparam logic signed [9:0]  EXP_DENORM  = -10'sd127;

   // Signed infinity with the given sign.
   function automatic logic [31:0] signed_inf(input logic sign);
      return {sign, 8'hFF, 23'd0};
   endfunction

   // Signed zero with the given sign.
   function automatic logic [31:0] signed_zero(input logic sign);
      return {sign, 31'd0};
   endfunction

endpackage

// File: rtl/fp32_classify.sv
// Classifies one unpacked fp32 operand (unbiased exponent, raw mantissa)
// into NaN / infinity / zero / denormal. Purely combinational.
module fp32_classify
   import fp32_pkg::*;
(
   input  logic signed [9:0] e,
   input  logic [23:0]       m,
   output logic              is_nan,
   output logic              is_inf,
   output logic              is_zero,
   output logic              is_denorm
);

   logic m_zero_s;

   assign m_zero_s  = (m == 24'd0);
   assign is_nan    = (e == EXP_SPECIAL) && !m_zero_s;
   assign is_inf    = (e == EXP_SPECIAL) && m_zero_s;
   assign is_zero   = (e == EXP_DENORM) && m_zero_s;
   assign is_denorm = (e == EXP_DENORM);

endmodule

// File: rtl/fp32_multiplier.sv
// Single-precision IEEE-754 multiplier, round to nearest / ties to even.
// Multi-cycle FSM with stb/ack handshakes on a, b and z; one operation in
// flight, latency grows with the number of normalisation shifts.
module fp32_multiplier
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   input  logic [31:0] input_b,
   input  logic        input_b_stb,
   output logic        input_b_ack,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);

   fp32_state_t       state_r;
   logic [31:0]       a_r, b_r, z_r;
   logic [23:0]       a_m_r, b_m_r, z_m_r;
   logic signed [9:0] a_e_r, b_e_r, z_e_r;
   logic              a_s_r, b_s_r, z_s_r;
   logic [47:0]       product_r;
   logic              guard_r, round_bit_r, sticky_r;

   logic a_nan_s, a_inf_s, a_zero_s, a_denorm_s;
   logic b_nan_s, b_inf_s, b_zero_s, b_denorm_s;

   fp32_classify u_classify_a (
      .e         (a_e_r),
      .m         (a_m_r),
      .is_nan    (a_nan_s),
      .is_inf    (a_inf_s),
      .is_zero   (a_zero_s),
      .is_denorm (a_denorm_s)
   );

   fp32_classify u_classify_b (
      .e         (b_e_r),
      .m         (b_m_r),
      .is_nan    (b_nan_s),
      .is_inf    (b_inf_s),
      .is_zero   (b_zero_s),
      .is_denorm (b_denorm_s)
   );

   // Control FSM and datapath: handshakes, unpack, multiply, normalise, round, pack.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= GET_A;
         input_a_ack  <= 1'b0;
         input_b_ack  <= 1'b0;
         output_z_stb <= 1'b0;
         output_z     <= 32'd0;
      end else begin
         case (state_r)
            GET_A: begin
               input_a_ack <= 1'b1;
               if (input_a_ack && input_a_stb) begin
                  a_r         <= input_a;
                  input_a_ack <= 1'b0;
                  state_r     <= GET_B;
               end
            end
            GET_B: begin
               input_b_ack <= 1'b1;
               if (input_b_ack && input_b_stb) begin
                  b_r         <= input_b;
                  input_b_ack <= 1'b0;
                  state_r     <= UNPACK;
               end
            end
            UNPACK: begin
               a_m_r   <= {1'b0, a_r[22:0]};
               b_m_r   <= {1'b0, b_r[22:0]};
               a_e_r   <= $signed({2'b00, a_r[30:23]}) - EXP_BIAS;
               b_e_r   <= $signed({2'b00, b_r[30:23]}) - EXP_BIAS;
               a_s_r   <= a_r[31];
               b_s_r   <= b_r[31];
               state_r <= SPECIAL_CASES;
            end
            SPECIAL_CASES: begin
               if (a_nan_s || b_nan_s) begin
                  z_r     <= QNAN;
                  state_r <= PUT_Z;
               end else if ((a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
                  z_r     <= QNAN;
                  state_r <= PUT_Z;
               end else if (a_inf_s || b_inf_s) begin
                  z_r     <= signed_inf(a_s_r ^ b_s_r);
                  state_r <= PUT_Z;
               end else if (a_zero_s || b_zero_s) begin
                  z_r     <= signed_zero(a_s_r ^ b_s_r);
                  state_r <= PUT_Z;
               end else begin
                  // Denormals keep a zero hidden bit and use the minimum exponent.
                  if (a_denorm_s) a_e_r <= EXP_MIN;
                  else            a_m_r[23] <= 1'b1;
                  if (b_denorm_s) b_e_r <= EXP_MIN;
                  else            b_m_r[23] <= 1'b1;
                  state_r <= NORMALISE_A;
               end
            end
            NORMALISE_A: begin
               if (!a_m_r[23]) begin
                  a_m_r <= {a_m_r[22:0], 1'b0};
                  a_e_r <= a_e_r - 10'sd1;
               end else begin
                  state_r <= NORMALISE_B;
               end
            end
            NORMALISE_B: begin
               if (!b_m_r[23]) begin
                  b_m_r <= {b_m_r[22:0], 1'b0};
                  b_e_r <= b_e_r - 10'sd1;
               end else begin
                  state_r <= MULTIPLY_0;
               end
            end
            MULTIPLY_0: begin
               z_s_r     <= a_s_r ^ b_s_r;
               // The +1 assumes the product lands in [2,4); normalise_1 undoes it otherwise.
               z_e_r     <= a_e_r + b_e_r + 10'sd1;
               product_r <= {24'd0, a_m_r} * {24'd0, b_m_r};
               state_r   <= MULTIPLY_1;
            end
            MULTIPLY_1: begin
               z_m_r       <= product_r[47:24];
               guard_r     <= product_r[23];
               round_bit_r <= product_r[22];
               sticky_r    <= |product_r[21:0];
               state_r     <= NORMALISE_1;
            end
            NORMALISE_1: begin
               if (!z_m_r[23]) begin
                  z_m_r       <= {z_m_r[22:0], guard_r};
                  guard_r     <= round_bit_r;
                  round_bit_r <= 1'b0;
                  z_e_r       <= z_e_r - 10'sd1;
               end else begin
                  state_r <= NORMALISE_2;
               end
            end
            NORMALISE_2: begin
               // Denormalise results below the minimum exponent, keeping rounding info.
               if (z_e_r < EXP_MIN) begin
                  z_m_r       <= {1'b0, z_m_r[23:1]};
                  z_e_r       <= z_e_r + 10'sd1;
                  guard_r     <= z_m_r[0];
                  round_bit_r <= guard_r;
                  sticky_r    <= sticky_r | round_bit_r;
               end else begin
                  state_r <= ROUND;
               end
            end
            ROUND: begin
               if (guard_r && (round_bit_r || sticky_r || z_m_r[0])) begin
                  z_m_r <= z_m_r + 24'd1;
                  if (z_m_r == 24'hFFFFFF) begin
                     z_e_r <= z_e_r + 10'sd1;
                  end
               end
               state_r <= PACK;
            end
            PACK: begin
               if (z_e_r > EXP_MAX) begin
                  z_r <= signed_inf(z_s_r);
               end else if ((z_e_r == EXP_MIN) && !z_m_r[23]) begin
                  z_r <= {z_s_r, 8'd0, z_m_r[22:0]};
               end else begin
                  z_r <= {z_s_r, z_e_r[7:0] + EXP_BIAS[7:0], z_m_r[22:0]};
               end
               state_r <= PUT_Z;
            end
            PUT_Z: begin
               output_z_stb <= 1'b1;
               output_z     <= z_r;
               if (output_z_stb && output_z_ack) begin
                  output_z_stb <= 1'b0;
                  state_r      <= GET_A;
               end
            end
            default: begin
               state_r <= GET_A;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp32_multiplier.sv
// Directed self-checking bench for fp32_multiplier.
module tb_fp32_multiplier;

   logic        clk;
   logic        rst;
   logic [31:0] input_a;
   logic        input_a_stb;
   logic        input_a_ack;
   logic [31:0] input_b;
   logic        input_b_stb;
   logic        input_b_ack;
   logic [31:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack;

   int tests_run;
   int tests_failed;

   fp32_multiplier dut (
      .clk          (clk),
      .rst          (rst),
      .input_a      (input_a),
      .input_a_stb  (input_a_stb),
      .input_a_ack  (input_a_ack),
      .input_b      (input_b),
      .input_b_stb  (input_b_stb),
      .input_b_ack  (input_b_ack),
      .output_z     (output_z),
      .output_z_stb (output_z_stb),
      .output_z_ack (output_z_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hands a then b to the DUT; returns at the negedge after the b-handshake edge.
   task automatic send_ab(input logic [31:0] a, input logic [31:0] b);
      int n;
      input_a = a;
      input_a_stb = 1'b1;
      n = 0;
      while (input_a_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      input_a_stb = 1'b0;
      input_b = b;
      input_b_stb = 1'b1;
      n = 0;
      while (input_b_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      input_b_stb = 1'b0;
   endtask

   // Counts cycles from the b-handshake edge until output_z_stb is seen high (-1 on timeout).
   task automatic wait_stb(output int lat);
      lat = 0;
      while (output_z_stb !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
      if (output_z_stb !== 1'b1) lat = -1;
   endtask

   // Accepts the pending result with a one-cycle ack pulse.
   task automatic take_z();
      output_z_ack = 1'b1;
      @(negedge clk);
      output_z_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      input_a = 32'd0; input_a_stb = 1'b0;
      input_b = 32'd0; input_b_stb = 1'b0;
      output_z_ack = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (output_z_stb !== 1'b0 || input_a_ack !== 1'b0 || input_b_ack !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got stb=%b a_ack=%b b_ack=%b, expected all 0",
                  output_z_stb, input_a_ack, input_b_ack);
      end
      tests_run++;
      if (output_z !== 32'd0) begin
         tests_failed++;
         $display("FAIL reset_z: got %h expected 00000000", output_z);
      end
      rst = 1'b0;
   endtask

   // Runs each vector as a full operation and checks result and latency.
   task automatic run_vectors(input string tag, input logic [31:0] va[], input logic [31:0] vb[],
                              input logic [31:0] vz[], input int vl[]);
      int lat;
      for (int i = 0; i < va.size(); i++) begin
         send_ab(va[i], vb[i]);
         wait_stb(lat);
         tests_run++;
         if (output_z !== vz[i]) begin
            tests_failed++;
            $display("FAIL %s_z[%0d]: %h x %h got %h expected %h", tag, i, va[i], vb[i], output_z, vz[i]);
         end
         tests_run++;
         if (lat !== vl[i]) begin
            tests_failed++;
            $display("FAIL %s_latency[%0d]: got %0d expected %0d", tag, i, lat, vl[i]);
         end
         take_z();
      end
   endtask

   task automatic test_basic();
      logic [31:0] va[] = '{32'h3FC00000, 32'h40000000, 32'h3F800001, 32'hBFC00000};
      logic [31:0] vb[] = '{32'h3FC00000, 32'h40400000, 32'h3F800001, 32'h40000000};
      logic [31:0] vz[] = '{32'h40100000, 32'h40C00000, 32'h3F800002, 32'hC0400000};
      int          vl[] = '{11, 12, 12, 12};
      run_vectors("basic", va, vb, vz, vl);
   endtask

   task automatic test_specials();
      logic [31:0] va[] = '{32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'h80000000};
      logic [31:0] vb[] = '{32'h3F800000, 32'h00000000, 32'h40000000, 32'h40000000};
      logic [31:0] vz[] = '{32'hFFC00000, 32'hFFC00000, 32'hFF800000, 32'h80000000};
      int          vl[] = '{3, 3, 3, 3};
      run_vectors("special", va, vb, vz, vl);
   endtask

   task automatic test_range();
      logic [31:0] va[] = '{32'h7F000000, 32'h00800000, 32'h00000001};
      logic [31:0] vb[] = '{32'h7F000000, 32'h3F000000, 32'h3F000000};
      logic [31:0] vz[] = '{32'h7F800000, 32'h00400000, 32'h00000000};
      int          vl[] = '{12, 13, 59};
      run_vectors("range", va, vb, vz, vl);
   endtask

   task automatic test_denormal();
      logic [31:0] va[] = '{32'h00000001, 32'h00000001};
      logic [31:0] vb[] = '{32'h4B000000, 32'h7E800000};
      logic [31:0] vz[] = '{32'h00800000, 32'h34000000};
      int          vl[] = '{35, 35};
      run_vectors("denorm", va, vb, vz, vl);
   endtask

   task automatic test_backpressure();
      int lat;
      int bad_stb, bad_z, bad_ack;
      send_ab(32'h40000000, 32'h40400000);
      wait_stb(lat);
      tests_run++;
      if (output_z !== 32'h40C00000) begin
         tests_failed++;
         $display("FAIL bp_z: got %h expected 40C00000", output_z);
      end
      bad_stb = 0; bad_z = 0; bad_ack = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (output_z_stb !== 1'b1) bad_stb++;
         if (output_z !== 32'h40C00000) bad_z++;
         if (input_a_ack !== 1'b0) bad_ack++;
      end
      tests_run++;
      if (bad_stb != 0 || bad_z != 0 || bad_ack != 0) begin
         tests_failed++;
         $display("FAIL bp_hold: got %0d/%0d/%0d bad cycles (stb/z/a_ack) expected 0/0/0",
                  bad_stb, bad_z, bad_ack);
      end
      take_z();
      tests_run++;
      if (output_z_stb !== 1'b0 || input_a_ack !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_release: got stb=%b a_ack=%b expected stb=0 a_ack=0",
                  output_z_stb, input_a_ack);
      end
      @(negedge clk);
      tests_run++;
      if (input_a_ack !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_a_ack_rise: got %b expected 1", input_a_ack);
      end
   endtask

   task automatic test_reset_mid_op();
      int lat;
      send_ab(32'h3F800000, 32'h3F800000);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if (output_z_stb !== 1'b0 || input_a_ack !== 1'b0 || input_b_ack !== 1'b0 || output_z !== 32'd0) begin
         tests_failed++;
         $display("FAIL midreset_state: got stb=%b a_ack=%b b_ack=%b z=%h expected 0/0/0/00000000",
                  output_z_stb, input_a_ack, input_b_ack, output_z);
      end
      send_ab(32'h3F800000, 32'h3F800000);
      wait_stb(lat);
      tests_run++;
      if (output_z !== 32'h3F800000) begin
         tests_failed++;
         $display("FAIL midreset_next_z: got %h expected 3F800000", output_z);
      end
      tests_run++;
      if (lat !== 12) begin
         tests_failed++;
         $display("FAIL midreset_next_latency: got %0d expected 12", lat);
      end
      take_z();
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_basic();
      test_specials();
      test_range();
      test_denormal();
      test_backpressure();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
